// File: rtl/mmio_master_if.sv
// Command/response handshake plus peripheral strobe bus for mmio_master.
// The master modport is the controller's view; slave is the requester/peripheral side.
interface mmio_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_we;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;

  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;

  logic              o_sel;
  logic              o_we;
  logic              o_re;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rdy;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_rsp_ready, i_rdata, i_rdy,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_sel, o_we, o_re, o_addr, o_wdata
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_rsp_ready, i_rdata, i_rdy,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_sel, o_we, o_re, o_addr, o_wdata
  );
endinterface

// File: rtl/mmio_master.sv
// Single-outstanding MMIO bus master: accepts a command, drives registered
// peripheral strobes until i_rdy or timeout, then holds the response until consumed.
module mmio_master #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mmio_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       accept, done_ok, done_to, consume;

  assign accept  = (state == IDLE) && bus.i_cmd_valid;
  assign done_ok = (state == BUS) && bus.i_rdy;
  // A ready peripheral on the last allowed cycle beats the timeout.
  assign done_to = (state == BUS) && !bus.i_rdy && (cnt == CNT_LAST);
  assign consume = (state == RESP) && bus.i_rsp_ready;

  assign bus.o_cmd_ready = (state == IDLE);
  assign bus.o_rsp_valid = (state == RESP);

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)             state_next = BUS;
      BUS:     if (done_ok || done_to) state_next = RESP;
      RESP:    if (consume)            state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // The registered bus outputs double as the latched command for the transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt             <= '0;
      bus.o_sel       <= 1'b0;
      bus.o_we        <= 1'b0;
      bus.o_re        <= 1'b0;
      bus.o_addr      <= '0;
      bus.o_wdata     <= '0;
      bus.o_rsp_rdata <= '0;
      bus.o_rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= '0;
      end else if ((state == BUS) && !bus.i_rdy && (cnt != 8'hFF)) begin
        cnt <= cnt + 8'd1;
      end

      if (accept) begin
        bus.o_sel   <= 1'b1;
        bus.o_we    <= bus.i_cmd_we;
        bus.o_re    <= ~bus.i_cmd_we;
        bus.o_addr  <= bus.i_cmd_addr;
        bus.o_wdata <= bus.i_cmd_wdata;
      end else if (done_ok || done_to) begin
        bus.o_sel   <= 1'b0;
        bus.o_we    <= 1'b0;
        bus.o_re    <= 1'b0;
        bus.o_addr  <= '0;
        bus.o_wdata <= '0;
      end

      if (done_ok) begin
        bus.o_rsp_rdata <= bus.o_re ? bus.i_rdata : '0;
        bus.o_rsp_err   <= 1'b0;
      end else if (done_to) begin
        bus.o_rsp_rdata <= '0;
        bus.o_rsp_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mmio_master.sv
// Self-checking bench for mmio_master: directed vector table, hand-written
// reset sequence, and randomized transactions checked against a rule-level model.
module tb_mmio_master;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int              rdy_cycle;   // bus cycle (1-based) on which i_rdy pulses; 0 = never
    logic [DATA_W-1:0] rdata;
    int              rsp_wait;    // cycles i_rsp_ready is held low
    int              exp_cycles;
    bit              exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mmio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mmio_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome straight from the transaction rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   hit;
    r   = v;
    hit = (v.rdy_cycle >= 1) && (v.rdy_cycle <= TIMEOUT);
    r.exp_cycles = hit ? v.rdy_cycle : TIMEOUT;
    r.exp_err    = !hit;
    r.exp_rdata  = (hit && !v.we) ? v.rdata : '0;
    return r;
  endfunction

  // Called aligned at posedge+1; returns aligned the same way.
  task automatic run_txn(input vec_t v);
    int sel_cnt;
    logic [DATA_W-1:0] rd_hold;
    logic              err_hold;
    check("cmd_ready_idle", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = v.we;
    bus.i_cmd_addr  = v.addr;
    bus.i_cmd_wdata = v.wdata;
    @(posedge i_clk); #1;
    // Junk commands while busy must be ignored and must not disturb the latch.
    bus.i_cmd_we    = ~v.we;
    bus.i_cmd_addr  = ADDR_W'($urandom);
    bus.i_cmd_wdata = DATA_W'($urandom);
    check("sel_after_accept", 32'(bus.o_sel), 32'd1);
    sel_cnt = 0;
    for (int k = 1; k <= 300 && bus.o_sel; k++) begin
      check("bus_we",    32'(bus.o_we),    32'(v.we));
      check("bus_re",    32'(bus.o_re),    32'(!v.we));
      check("bus_addr",  32'(bus.o_addr),  32'(v.addr));
      check("bus_wdata", 32'(bus.o_wdata), 32'(v.wdata));
      check("cmd_ready_busy", 32'(bus.o_cmd_ready), 32'd0);
      sel_cnt++;
      bus.i_rdy   = (k == v.rdy_cycle);
      bus.i_rdata = (k == v.rdy_cycle) ? v.rdata : DATA_W'($urandom);
      @(posedge i_clk); #1;
    end
    bus.i_rdy = 1'b0;
    check("sel_dropped", 32'(bus.o_sel), 32'd0);
    check("sel_cycles", 32'(sel_cnt), 32'(v.exp_cycles));
    check("bus_re_idle", 32'(bus.o_re | bus.o_we), 32'd0);
    check("rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    check("rsp_rdata", 32'(bus.o_rsp_rdata), 32'(v.exp_rdata));
    check("rsp_err",   32'(bus.o_rsp_err),   32'(v.exp_err));
    rd_hold  = bus.o_rsp_rdata;
    err_hold = bus.o_rsp_err;
    for (int w = 0; w < v.rsp_wait; w++) begin
      bus.i_rsp_ready = 1'b0;
      bus.i_rdata     = DATA_W'($urandom);
      @(posedge i_clk); #1;
      check("rsp_hold_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("rsp_hold_rdata", 32'(bus.o_rsp_rdata), 32'(rd_hold));
      check("rsp_hold_err",   32'(bus.o_rsp_err),   32'(err_hold));
      check("cmd_ready_resp", 32'(bus.o_cmd_ready), 32'd0);
      check("no_queued_sel",  32'(bus.o_sel),       32'd0);
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_rsp_ready = 1'b0;
    check("rsp_consumed", 32'(bus.o_rsp_valid), 32'd0);
    check("cmd_ready_back", 32'(bus.o_cmd_ready), 32'd1);
    check("sel_idle", 32'(bus.o_sel), 32'd0);
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_wdata = '0;
    bus.i_rsp_ready = 1'b0;
    bus.i_rdata     = '0;
    bus.i_rdy       = 1'b0;

    //          we  addr   wdata     rdy  rdata     wait cyc err exp_rdata
    vecs[0] = '{1'b1, 2'd0, 16'h0003, 1,  16'hAAAA, 0,   1,  1'b0, 16'h0000};
    vecs[1] = '{1'b0, 2'd2, 16'h5555, 1,  16'hFFFC, 0,   1,  1'b0, 16'hFFFC};
    vecs[2] = '{1'b0, 2'd1, 16'h0000, 0,  16'h0000, 1,   15, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 2'd3, 16'h0000, 3,  16'h1234, 4,   3,  1'b0, 16'h1234};
    vecs[4] = '{1'b0, 2'd1, 16'h0000, 15, 16'hBEEF, 0,   15, 1'b0, 16'hBEEF};
    vecs[5] = '{1'b0, 2'd2, 16'h0000, 16, 16'hBEEF, 2,   15, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 2'd3, 16'hC0DE, 0,  16'h0000, 0,   15, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 2'd1, 16'h8001, 5,  16'h7777, 1,   5,  1'b0, 16'h0000};

    #12;
    check("rst_sel",       32'(bus.o_sel),       32'd0);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.o_rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(bus.o_rsp_err),   32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("cmd_ready_after_rst", 32'(bus.o_cmd_ready), 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset during the second cycle of a stalled read aborts it outright.
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 2'd2;
    bus.i_cmd_wdata = '0;
    bus.i_rdy       = 1'b0;
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b0;
    check("abort_sel_c1", 32'(bus.o_sel), 32'd1);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("abort_sel",       32'(bus.o_sel),       32'd0);
    check("abort_re",        32'(bus.o_re),        32'd0);
    check("abort_addr",      32'(bus.o_addr),      32'd0);
    check("abort_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("abort_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    @(posedge i_clk); #1;
    check("abort_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    rv = '{1'b1, 2'd0, 16'h0003, 1, 16'h0000, 0, 0, 1'b0, 16'h0000};
    run_txn(model(rv));

    for (int n = 0; n < 25; n++) begin
      rv.we        = 1'($urandom_range(0, 1));
      rv.addr      = ADDR_W'($urandom);
      rv.wdata     = DATA_W'($urandom);
      rv.rdy_cycle = $urandom_range(0, TIMEOUT + 3);
      rv.rdata     = DATA_W'($urandom);
      rv.rsp_wait  = $urandom_range(0, 3);
      run_txn(model(rv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_master.md
MMIO_MASTER -- requirements
Module: mmio_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, peripheral word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum bus cycles waiting for i_rdy (range 1..255).
REQ-004 SHALL use one clock and asynchronous active-low reset; ports follow:
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_cmd_valid  in  1  command request.
REQ-008 o_cmd_ready  out  1  command accepted when valid&ready at posedge.
REQ-009 i_cmd_we  in  1  1=write, 0=read.
REQ-010 i_cmd_addr  in  ADDR_W  target register address.
REQ-011 i_cmd_wdata  in  DATA_W  write data.
REQ-012 o_rsp_valid  out  1  response available.
REQ-013 i_rsp_ready  in  1  response consumed when valid&ready at posedge.
REQ-014 o_rsp_rdata  out  DATA_W  read data (0 for writes and errors).
REQ-015 o_rsp_err  out  1  transaction timed out.
REQ-016 o_sel, o_we, o_re  out  1 each  peripheral select/write/read strobes.
REQ-017 o_addr  out  ADDR_W; o_wdata  out  DATA_W  peripheral address/data.
REQ-018 i_rdata  in  DATA_W; i_rdy  in  1  peripheral read data / ready.

Function
REQ-019 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; one transaction outstanding.
REQ-020 o_cmd_ready SHALL be 1 only in IDLE (combinational from state).
REQ-021 IDLE: on accept, latch we/addr/wdata, clear timeout counter, go BUS.
REQ-022 All bus outputs SHALL be registered; in BUS: o_sel=1, o_we=we, o_re=~we, o_addr/o_wdata = latched values; outside BUS all bus outputs 0.
REQ-023 Bus outputs SHALL stay stable for the whole BUS state.
REQ-024 BUS: at each posedge with i_rdy=1, complete: read captures i_rdata into o_rsp_rdata, write sets o_rsp_rdata=0; o_rsp_err=0; go RESP.
REQ-025 BUS: at posedge with i_rdy=0, increment counter; when counter reaches TIMEOUT-1 at that edge (i.e. TIMEOUT cycles without i_rdy), complete with o_rsp_err=1, o_rsp_rdata=0, go RESP.
REQ-026 i_rdy=1 on the timeout cycle SHALL win (normal completion, err=0).
REQ-027 Minimum latency: accept at edge N, bus active N..N+1, rsp_valid high after edge N+1 (i_rdy=1 constantly).
REQ-028 RESP: o_rsp_valid=1, o_rsp_rdata/o_rsp_err held stable until i_rsp_ready=1 at a posedge, then IDLE; o_cmd_ready returns the following cycle.
REQ-029 i_cmd_valid outside IDLE SHALL be ignored; no command queueing.
REQ-030 Counter SHALL be 8 bits, never wrap (cleared on accept).
REQ-031 i_cmd_* SHALL be sampled only at accept; changes afterwards have no effect.

Reset
REQ-032 On i_rst_n=0, asynchronously: state IDLE, all bus outputs 0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, counter 0.
REQ-033 Reset mid-BUS or mid-RESP SHALL abort the transaction with no response; o_sel falls immediately.
REQ-034 After deassertion, o_cmd_ready=1 in the first cycle.

Verification
REQ-035 Write addr 0 data 0x0003, i_rdy=1 -> one cycle o_sel=1,o_we=1,o_addr=0,o_wdata=0x0003; rsp_valid next, rdata=0x0000, err=0.
REQ-036 Read addr 2, peripheral returns 0xFFFC with i_rdy=1 -> o_re=1 one cycle; rsp rdata=0xFFFC, err=0.
REQ-037 Read with i_rdy held 0, TIMEOUT=15 -> o_sel high exactly 15 cycles, then rsp err=1, rdata=0x0000.
REQ-038 i_rdy asserted on 3rd bus cycle of read returning 0x1234 -> o_sel high 3 cycles, rdata=0x1234, err=0; i_rsp_ready held 0 for 4 cycles -> rsp fields stable, o_cmd_ready=0 throughout.
REQ-039 Assert i_rst_n=0 in cycle 2 of a stalled read -> bus outputs and o_rsp_valid 0 immediately; after release o_cmd_ready=1 and next write completes normally.
